// File: rtl/cpu86_mem_pkg.sv
// Shared types and constants for the cpu86 memory initiator.
// Byte offset k within a 32-bit memory word lives at bits [31-8k:24-8k].
package cpu86_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LO,
        ST_WR_HI,
        ST_RD_LO,
        ST_RD_LO_CAP,
        ST_RD_HI,
        ST_RD_HI_CAP,
        ST_RESP
    } state_t;

    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

    localparam logic [3:0] MASK_IDLE = 4'hF;
    localparam logic [1:0] OFF_LAST  = 2'd3;

    function automatic logic [7:0] lane_get(
        input logic [31:0] q,
        input logic [1:0]  k
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (k)
            2'd0: b = q[LANE0_LSB +: 8];
            2'd1: b = q[LANE1_LSB +: 8];
            2'd2: b = q[LANE2_LSB +: 8];
            2'd3: b = q[LANE3_LSB +: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cpu86_mem_lane_mux.sv
// Places one or two little-endian bytes into 32-bit memory lanes
// and produces the matching active-low byte-enable mask.
module cpu86_mem_lane_mux
    import cpu86_mem_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic        i_word,
    input  logic [15:0] i_data,
    output logic [31:0] o_data,
    output logic [3:0]  o_mask
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;

    assign w_lo = i_data[7:0];
    assign w_hi = i_data[15:8];

    // Low byte at the offset lane, high byte in the next lane up;
    // at offset 3 the high byte belongs to the next word and is dropped.
    always_comb begin
        o_data = 32'h0000_0000;
        o_mask = MASK_IDLE;
        unique case (i_off)
            2'd0: begin
                o_data[LANE0_LSB +: 8] = w_lo;
                o_mask[3]              = 1'b0;
                if (i_word) begin
                    o_data[LANE1_LSB +: 8] = w_hi;
                    o_mask[2]              = 1'b0;
                end
            end
            2'd1: begin
                o_data[LANE1_LSB +: 8] = w_lo;
                o_mask[2]              = 1'b0;
                if (i_word) begin
                    o_data[LANE2_LSB +: 8] = w_hi;
                    o_mask[1]              = 1'b0;
                end
            end
            2'd2: begin
                o_data[LANE2_LSB +: 8] = w_lo;
                o_mask[1]              = 1'b0;
                if (i_word) begin
                    o_data[LANE3_LSB +: 8] = w_hi;
                    o_mask[0]              = 1'b0;
                end
            end
            2'd3: begin
                o_data[LANE3_LSB +: 8] = w_lo;
                o_mask[0]              = 1'b0;
            end
            default: begin
                o_data = 32'h0000_0000;
                o_mask = MASK_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cpu86_mem_initiator.sv
// Turns 8/16-bit CPU byte-address requests into 32-bit word memory
// accesses, splitting a word that straddles a memory-word boundary.
module cpu86_mem_initiator
    import cpu86_mem_pkg::*;
#(
    parameter int AW = 25
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s_req_valid,
    output logic          s_req_ready,
    input  logic          s_req_we,
    input  logic          s_req_word,
    input  logic [AW+1:0] s_req_addr,
    input  logic [15:0]   s_req_data,
    output logic          m_res_valid,
    input  logic          m_res_ready,
    output logic [15:0]   m_res_data,
    output logic          mem_we,
    output logic [3:0]    mem_wmask,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_q
);

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic          r_word;
    logic [1:0]    r_off;
    logic [AW-1:0] r_wa;
    logic [15:0]   r_data;
    logic [15:0]   r_rdata;
    logic [AW-1:0] r_raddr;

    logic          w_accept;
    logic          w_split;
    logic [AW-1:0] w_wa_hi;
    logic [1:0]    w_off_nx;
    logic          w_in_hi;
    logic [1:0]    w_mux_off;
    logic          w_mux_word;
    logic [15:0]   w_mux_din;
    logic [31:0]   w_mux_data;
    logic [3:0]    w_mux_mask;

    assign w_accept = s_req_valid & (r_state == ST_IDLE);
    assign w_split  = r_word & (r_off == OFF_LAST);
    assign w_wa_hi  = r_wa + AW'(1);
    assign w_off_nx = r_off + 2'd1;

    // The high half of a split word is a single byte in lane 0.
    assign w_in_hi    = (r_state == ST_WR_HI);
    assign w_mux_off  = w_in_hi ? 2'd0 : r_off;
    assign w_mux_word = w_in_hi ? 1'b0 : r_word;
    assign w_mux_din  = w_in_hi ? {8'h00, r_data[15:8]} : r_data;

    cpu86_mem_lane_mux u_lane_mux (
        .i_off  (w_mux_off),
        .i_word (w_mux_word),
        .i_data (w_mux_din),
        .o_data (w_mux_data),
        .o_mask (w_mux_mask)
    );

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing of write and read paths.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = s_req_we ? ST_WR_LO : ST_RD_LO;
                end
            end
            ST_WR_LO:     w_next = w_split ? ST_WR_HI : ST_RESP;
            ST_WR_HI:     w_next = ST_RESP;
            ST_RD_LO:     w_next = ST_RD_LO_CAP;
            ST_RD_LO_CAP: w_next = w_split ? ST_RD_HI : ST_RESP;
            ST_RD_HI:     w_next = ST_RD_HI_CAP;
            ST_RD_HI_CAP: w_next = ST_RESP;
            ST_RESP: begin
                if (m_res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default:      w_next = ST_IDLE;
        endcase
    end

    // Handshake and write-port outputs decoded from the state.
    always_comb begin
        s_req_ready = 1'b0;
        m_res_valid = 1'b0;
        mem_we      = 1'b0;
        mem_wmask   = MASK_IDLE;
        mem_waddr   = '0;
        mem_wdata   = 32'h0000_0000;
        unique case (r_state)
            ST_IDLE: s_req_ready = 1'b1;
            ST_WR_LO: begin
                mem_we    = 1'b1;
                mem_wmask = w_mux_mask;
                mem_waddr = r_wa;
                mem_wdata = w_mux_data;
            end
            ST_WR_HI: begin
                mem_we    = 1'b1;
                mem_wmask = w_mux_mask;
                mem_waddr = w_wa_hi;
                mem_wdata = w_mux_data;
            end
            ST_RESP: m_res_valid = 1'b1;
            default: begin
                s_req_ready = 1'b0;
            end
        endcase
    end

    // Request latch, read address and read-data assembly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we    <= 1'b0;
            r_word  <= 1'b0;
            r_off   <= 2'd0;
            r_wa    <= '0;
            r_data  <= 16'h0000;
            r_rdata <= 16'h0000;
            r_raddr <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= s_req_we;
                r_word  <= s_req_word;
                r_off   <= s_req_addr[1:0];
                r_wa    <= s_req_addr[AW+1:2];
                r_data  <= s_req_data;
                r_rdata <= 16'h0000;
                if (!s_req_we) begin
                    r_raddr <= s_req_addr[AW+1:2];
                end
            end
            if (r_state == ST_RD_LO_CAP) begin
                if (w_split) begin
                    r_rdata <= {8'h00, lane_get(mem_q, OFF_LAST)};
                    r_raddr <= w_wa_hi;
                end else if (r_word) begin
                    r_rdata <= {lane_get(mem_q, w_off_nx),
                                lane_get(mem_q, r_off)};
                end else begin
                    r_rdata <= {8'h00, lane_get(mem_q, r_off)};
                end
            end
            if (r_state == ST_RD_HI_CAP) begin
                r_rdata[15:8] <= lane_get(mem_q, 2'd0);
            end
        end
    end

    assign mem_raddr  = r_raddr;
    assign m_res_data = r_rdata;

endmodule

// File: tb/tb_cpu86_mem_initiator.sv
// Bench for cpu86_mem_initiator: a word memory behind the DUT and a
// byte-addressed reference model of what the CPU should observe.
module tb_cpu86_mem_initiator;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_req_valid = 1'b0;
    logic          s_req_ready;
    logic          s_req_we = 1'b0;
    logic          s_req_word = 1'b0;
    logic [AW+1:0] s_req_addr = '0;
    logic [15:0]   s_req_data = 16'h0;
    logic          m_res_valid;
    logic          m_res_ready = 1'b0;
    logic [15:0]   m_res_data;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_q;

    int n_pass = 0;
    int n_total = 0;

    cpu86_mem_initiator #(.AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_we(s_req_we), .s_req_word(s_req_word),
        .s_req_addr(s_req_addr), .s_req_data(s_req_data),
        .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
        .m_res_data(m_res_data),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Word memory; the low region and the top region of the address
    // space are folded into 64 entries.
    bit [31:0]   mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;

    function automatic logic [5:0] widx(input logic [AW-1:0] a);
        return {a[AW-1], a[4:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++)
            if (!m[3-k]) r[31-8*k -: 8] = d[31-8*k -: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        mem_q <= mem[widx(mem_raddr)];
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we === 1'b1)
            mem[widx(mem_waddr)] <= merge(mem[widx(mem_waddr)], mem_wdata, mem_wmask);
    end

    // Record every write pulse.
    int            pcnt = 0;
    logic [AW-1:0] p_addr [$];
    logic [31:0]   p_data [$];
    logic [3:0]    p_mask [$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            p_addr.push_back(mem_waddr);
            p_data.push_back(mem_wdata);
            p_mask.push_back(mem_wmask);
            pcnt <= pcnt + 1;
        end
    end

    // Reference model: one byte per CPU byte address.
    bit [7:0] rb [256];

    function automatic logic [7:0] ridx(input logic [AW+1:0] a);
        return {a[AW+1], a[6:0]};
    endfunction

    task automatic ref_wr(input logic word, input logic [AW+1:0] a, input logic [15:0] d);
        logic [AW+1:0] a1;
        a1 = a + (AW+2)'(1);
        rb[ridx(a)] = d[7:0];
        if (word) rb[ridx(a1)] = d[15:8];
    endtask

    function automatic logic [15:0] exp_rd(input logic word, input logic [AW+1:0] a);
        logic [AW+1:0] a1;
        a1 = a + (AW+2)'(1);
        return word ? {rb[ridx(a1)], rb[ridx(a)]} : {8'h00, rb[ridx(a)]};
    endfunction

    function automatic int exp_lat(input logic we, input logic word, input logic [AW+1:0] a);
        bit sp;
        sp = word && (a[1:0] == 2'd3);
        return we ? (sp ? 3 : 2) : (sp ? 5 : 3);
    endfunction

    task automatic do_req(input logic we, input logic word, input logic [AW+1:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat);
        int  n;
        bit  got;
        @(negedge clk);
        s_req_we = we; s_req_word = word; s_req_addr = a; s_req_data = d;
        s_req_valid = 1'b1;
        n = 0;
        while (s_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_total++;
            $display("FAIL accept_timeout waited %0d cycles, need ready", n);
        end
        @(posedge clk);
        #1 s_req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = (m_res_valid === 1'b1);
        end
        rd = m_res_data;
        m_res_ready = 1'b1;
        @(posedge clk);
        #1 m_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({mem_we, mem_wmask, m_res_valid} !== 6'b0_1111_0)
            $display("FAIL reset_ctrl got we/mask/valid=%b want 011110", {mem_we, mem_wmask, m_res_valid});
        else n_pass++;
        n_total++;
        if (mem_waddr !== '0 || mem_raddr !== '0 || mem_wdata !== 32'h0 || m_res_data !== 16'h0)
            $display("FAIL reset_data got wa=%h ra=%h wd=%h rd=%h want 0", mem_waddr, mem_raddr, mem_wdata, m_res_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reads();
        logic [15:0] rd;
        int lat, base;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pl_en = 1'b1;
            pl_idx = 6'(i);
            pl_data = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        end
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 12; i++) rb[i] = 8'(i);
        base = pcnt;
        do_req(1'b0, 1'b0, (AW+2)'(6), 16'h0, rd, lat);
        n_total++;
        if (rd !== 16'h0006) $display("FAIL byte_read got %h want 0006", rd); else n_pass++;
        n_total++;
        if (lat !== 3) $display("FAIL byte_read_lat got %0d want 3", lat); else n_pass++;
        do_req(1'b0, 1'b1, (AW+2)'(3), 16'h0, rd, lat);
        n_total++;
        if (rd !== 16'h0403) $display("FAIL split_read got %h want 0403", rd); else n_pass++;
        n_total++;
        if (lat !== 5) $display("FAIL split_read_lat got %0d want 5", lat); else n_pass++;
        n_total++;
        if (pcnt !== base) $display("FAIL read_no_write got %0d pulses want 0", pcnt - base); else n_pass++;
    endtask

    task automatic test_aligned_write();
        logic [15:0] rd;
        int lat, base;
        base = pcnt;
        do_req(1'b1, 1'b1, (AW+2)'('h10), 16'h1234, rd, lat);
        ref_wr(1'b1, (AW+2)'('h10), 16'h1234);
        n_total++;
        if (lat !== 2) $display("FAIL aw_lat got %0d want 2", lat); else n_pass++;
        n_total++;
        if (pcnt - base !== 1) $display("FAIL aw_pulses got %0d want 1", pcnt - base); else n_pass++;
        n_total++;
        if (pcnt > base && {p_addr[base], p_data[base], p_mask[base]} !== {AW'(4), 32'h34120000, 4'b0011})
            $display("FAIL aw_beat got a=%h d=%h m=%b want 4 34120000 0011", p_addr[base], p_data[base], p_mask[base]);
        else n_pass++;
        n_total++;
        if (rd !== 16'h0) $display("FAIL aw_resp_data got %h want 0000", rd); else n_pass++;
    endtask

    task automatic chk_split_beats(input int base, input logic [AW-1:0] a0,
                                   input logic [AW-1:0] a1, input logic [15:0] d);
        n_total++;
        if (pcnt - base !== 2) begin
            $display("FAIL sw_pulses got %0d want 2", pcnt - base);
        end else if (p_addr[base] !== a0 || p_mask[base] !== 4'b1110 || p_data[base][7:0] !== d[7:0] ||
                     p_addr[base+1] !== a1 || p_mask[base+1] !== 4'b0111 || p_data[base+1][31:24] !== d[15:8]) begin
            $display("FAIL sw_beats got %h/%b/%h %h/%b/%h want %h/1110/lo %h/0111/hi d=%h",
                     p_addr[base], p_mask[base], p_data[base], p_addr[base+1], p_mask[base+1], p_data[base+1], a0, a1, d);
        end else n_pass++;
    endtask

    task automatic test_split_write();
        logic [15:0] rd;
        int lat, base;
        base = pcnt;
        do_req(1'b1, 1'b1, (AW+2)'(7), 16'hBEEF, rd, lat);
        ref_wr(1'b1, (AW+2)'(7), 16'hBEEF);
        n_total++;
        if (lat !== 3) $display("FAIL sw_lat got %0d want 3", lat); else n_pass++;
        chk_split_beats(base, AW'(1), AW'(2), 16'hBEEF);
    endtask

    task automatic test_wrap();
        logic [15:0] rd, d;
        logic [AW+1:0] a;
        int lat, base;
        a = '1;
        d = 16'($urandom);
        base = pcnt;
        do_req(1'b1, 1'b1, a, d, rd, lat);
        ref_wr(1'b1, a, d);
        n_total++;
        if (lat !== 3) $display("FAIL wrap_wlat got %0d want 3", lat); else n_pass++;
        chk_split_beats(base, '1, '0, d);
        do_req(1'b0, 1'b1, a, 16'h0, rd, lat);
        n_total++;
        if (rd !== d) $display("FAIL wrap_read got %h want %h", rd, d); else n_pass++;
        n_total++;
        if (lat !== 5) $display("FAIL wrap_rlat got %0d want 5", lat); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] ex;
        int n, base;
        ex = exp_rd(1'b1, (AW+2)'('h10));
        @(negedge clk);
        s_req_we = 1'b0; s_req_word = 1'b1; s_req_addr = (AW+2)'('h10); s_req_valid = 1'b1;
        n = 0;
        while (s_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 s_req_valid = 1'b0;
        n = 0;
        while (m_res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        s_req_we = 1'b1; s_req_word = 1'b0; s_req_addr = (AW+2)'('h20); s_req_valid = 1'b1;
        base = pcnt;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (m_res_valid !== 1'b1 || m_res_data !== ex || s_req_ready !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want 1 %h 0", i, m_res_valid, m_res_data, s_req_ready, ex);
            else n_pass++;
            @(negedge clk);
        end
        m_res_ready = 1'b1;
        @(posedge clk);
        #1 m_res_ready = 1'b0;
        s_req_valid = 1'b0;
        n_total++;
        if (s_req_ready !== 1'b1 || m_res_valid !== 1'b0)
            $display("FAIL bp_release got rdy=%b v=%b want 1 0", s_req_ready, m_res_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (pcnt !== base) $display("FAIL bp_no_accept got %0d pulses want 0", pcnt - base); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, rd, ex;
        int n, lat;
        bit got;
        d = 16'($urandom);
        @(negedge clk);
        s_req_we = 1'b1; s_req_word = 1'b1; s_req_addr = (AW+2)'('h2B); s_req_data = d;
        s_req_valid = 1'b1;
        n = 0;
        while (s_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 s_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (mem_we !== 1'b1 || mem_waddr !== AW'('hB))
            $display("FAIL rm_in_hi got we=%b wa=%h want 1 b", mem_we, mem_waddr);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_total++;
        if (mem_we !== 1'b0 || mem_wmask !== 4'hF || m_res_valid !== 1'b0)
            $display("FAIL rm_async got we=%b m=%b v=%b want 0 1111 0", mem_we, mem_wmask, m_res_valid);
        else n_pass++;
        ref_wr(1'b0, (AW+2)'('h2B), d);
        got = 1'b0;
        repeat (3) begin @(negedge clk); if (m_res_valid !== 1'b0) got = 1'b1; end
        n_total++;
        if (got) $display("FAIL rm_no_resp got valid=1 want 0"); else n_pass++;
        resetn = 1'b1;
        s_req_we = 1'b0; s_req_word = 1'b0; s_req_addr = (AW+2)'('h2B); s_req_valid = 1'b1;
        @(posedge clk);
        #1 s_req_valid = 1'b0;
        n_total++;
        if (s_req_ready !== 1'b0) $display("FAIL rm_first_edge got ready=%b want 0", s_req_ready); else n_pass++;
        n = 0;
        while (m_res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        ex = exp_rd(1'b0, (AW+2)'('h2B));
        n_total++;
        if (m_res_data !== ex) $display("FAIL rm_lo_written got %h want %h", m_res_data, ex); else n_pass++;
        m_res_ready = 1'b1;
        @(posedge clk);
        #1 m_res_ready = 1'b0;
        do_req(1'b0, 1'b0, (AW+2)'('h2C), 16'h0, rd, lat);
        ex = exp_rd(1'b0, (AW+2)'('h2C));
        n_total++;
        if (rd !== ex) $display("FAIL rm_hi_untouched got %h want %h", rd, ex); else n_pass++;
    endtask

    task automatic test_random();
        logic we, word, top;
        logic [6:0] lo;
        logic [AW+1:0] a;
        logic [15:0] d, rd, ex;
        int lat, el, ep, base;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            word = 1'($urandom_range(0, 1));
            top = 1'($urandom_range(0, 1));
            lo = 7'($urandom_range(0, 127));
            a = {{(AW-5){top}}, lo};
            d = 16'($urandom);
            ex = we ? 16'h0 : exp_rd(word, a);
            el = exp_lat(we, word, a);
            ep = we ? ((word && a[1:0] == 2'd3) ? 2 : 1) : 0;
            base = pcnt;
            do_req(we, word, a, d, rd, lat);
            if (we) ref_wr(word, a, d);
            n_total++;
            if (rd !== ex) $display("FAIL rnd%0d_data we=%b w=%b a=%h got %h want %h", i, we, word, a, rd, ex);
            else n_pass++;
            n_total++;
            if (lat !== el) $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, el); else n_pass++;
            n_total++;
            if (pcnt - base !== ep) $display("FAIL rnd%0d_pulses got %0d want %0d", i, pcnt - base, ep);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reads();
        test_aligned_write();
        test_split_write();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
